// File: rtl/ipq_pkg.sv
// rtl/ipq_pkg.sv - shared types and constants for the instruction prefetch queue
package ipq_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ipq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ipq_entry_t;

    // Fetch addresses are always word aligned; low two bits of a target are ignored.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ipq_fifo.sv
// rtl/ipq_fifo.sv - circular entry store for the prefetch queue with push/pop/flush
module ipq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != DEPTH_C) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; readers gate the head with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - single-outstanding instruction prefetcher feeding decode
// Optional same-cycle ack-to-decode bypass is built when IPQ_BYPASS_EN is defined.
module instr_prefetch_queue
    import ipq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_data_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ipq_state_e        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;

    ipq_entry_t        head;
    ipq_entry_t        push_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    logic              can_fetch;
    logic              accept;

    // Requests only leave IDLE with a free slot, so the returning ack always fits.
    assign can_fetch = (fifo_count < DEPTH_C);
    assign accept    = (state == WAIT) && mem_ack_i && !redirect_i;

    assign push_entry.pc    = req_addr;
    assign push_entry.instr = mem_data_i;
    assign mem_addr_o       = req_addr;

`ifdef IPQ_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit    = accept && fifo_empty;
    assign fifo_push     = accept && !fifo_full && !(bypass_hit && instr_ready_i);
    assign fifo_pop      = !fifo_empty && instr_ready_i && !redirect_i;
    assign instr_valid_o = !fifo_empty || bypass_hit;
    assign instr_o       = !fifo_empty ? head.instr : (bypass_hit ? mem_data_i : '0);
    assign instr_pc_o    = !fifo_empty ? head.pc    : (bypass_hit ? req_addr   : '0);
`else
    assign fifo_push     = accept && !fifo_full;
    assign fifo_pop      = !fifo_empty && instr_ready_i && !redirect_i;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? '0 : head.instr;
    assign instr_pc_o    = fifo_empty ? '0 : head.pc;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            mem_req_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc <= align_pc(redirect_pc_i);
                    end else if (can_fetch) begin
                        mem_req_o <= 1'b1;
                        req_addr  <= fetch_pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                        fetch_pc  <= redirect_i ? align_pc(redirect_pc_i) : fetch_pc + PC_STEP;
                    end else if (redirect_i) begin
                        fetch_pc <= align_pc(redirect_pc_i);
                        state    <= DROP;
                    end
                end
                DROP: begin
                    // Old request stays on the bus until memory answers; its data is discarded.
                    if (redirect_i) fetch_pc <= align_pc(redirect_pc_i);
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    ipq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_i),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning queue entry count (power of two, 2..16).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL provide clk_i  input  1  system clock, all state on rising edge.
REQ-004 SHALL provide rst_i  input  1  asynchronous active-low reset.
REQ-005 SHALL provide mem_req_o  output  1  fetch request to instruction memory.
REQ-006 SHALL provide mem_addr_o  output  32  word-aligned fetch address.
REQ-007 SHALL provide mem_ack_i  input  1  memory returns mem_data_i for the current request this cycle.
REQ-008 SHALL provide mem_data_i  input  32  fetched instruction word.
REQ-009 SHALL provide redirect_i  input  1  branch/jump taken; flush and restart.
REQ-010 SHALL provide redirect_pc_i  input  32  new fetch address.
REQ-011 SHALL provide instr_valid_o  output  1  queue head valid toward decode.
REQ-012 SHALL provide instr_o  output  32  head instruction word.
REQ-013 SHALL provide instr_pc_o  output  32  address of head instruction.
REQ-014 SHALL provide instr_ready_i  input  1  decode consumes head this cycle.

Function
REQ-015 SHALL run FSM states IDLE, WAIT, DROP; at most one request outstanding.
REQ-016 IDLE: SHALL assert mem_req_o and enter WAIT when queue occupancy < DEPTH and redirect_i low.
REQ-017 WAIT: mem_req_o and mem_addr_o SHALL stay constant until mem_ack_i.
REQ-018 On mem_ack_i in WAIT without redirect: SHALL push {fetch_pc, mem_data_i}, fetch_pc += 4, go IDLE.
REQ-019 fetch_pc SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 (modulo 2^32).
REQ-020 Handshake: pop occurs when instr_valid_o && instr_ready_i; instr_valid_o = queue not empty.
REQ-021 Ack-to-valid latency SHALL be 1 cycle (entry visible cycle after ack).
REQ-022 Push and pop in same cycle SHALL leave occupancy unchanged, legal when full.
REQ-023 Full: no new request issued; pending ack always has a slot (occupancy+outstanding <= DEPTH).
REQ-024 redirect_i SHALL flush queue (instr_valid_o low next cycle), load fetch_pc = {redirect_pc_i[31:2],2'b00}; it has priority over push and pop.
REQ-025 Redirect in WAIT without ack: SHALL go DROP, keep old request until ack, discard data, then IDLE.
REQ-026 Redirect coincident with ack: data SHALL be discarded, go IDLE.
REQ-027 Redirect in DROP: SHALL update fetch_pc only, remain in DROP.
REQ-028 mem_ack_i in IDLE SHALL be ignored.

Reset
REQ-029 rst_i low SHALL asynchronously force state IDLE, queue empty, fetch_pc = RESET_PC, mem_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
REQ-030 Reset mid-request SHALL drop the transaction; first request after release SHALL address RESET_PC.

Configuration
REQ-031 Macro IPQ_BYPASS_EN defined: when queue empty and mem_ack_i in WAIT, data SHALL appear on instr_o/instr_pc_o with instr_valid_o high the same cycle; if instr_ready_i also high, entry SHALL not be written.
REQ-032 Macro undefined: no combinational mem_ack_i-to-output path; latency per REQ-021.

Structure
REQ-033 Package ipq_pkg SHALL hold state enum (IDLE/WAIT/DROP), ADDR_W=32, INSTR_W=32, PC_STEP=4.
REQ-034 Storage SHALL be a sub-module ipq_fifo (DEPTH x 64-bit, push/pop/flush, full/empty/count).

Verification
REQ-035 Reset, RESET_PC=0, ack every 1 cycle, ready=1: pc stream 0x0,0x4,0x8 on instr_pc_o, data matches memory.
REQ-036 ready=0 for 10 cycles: exactly DEPTH=4 entries accepted, mem_req_o low once full, no data lost when ready returns.
REQ-037 Redirect to 0x0000_0103 while WAIT, ack 3 cycles later: that data dropped, next request addr 0x0000_0100, queue empty meanwhile.
REQ-038 Redirect and ack same cycle: no push, next address = redirect target.
REQ-039 Redirect to 0xFFFF_FFF8: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 rst_i low during WAIT, released: mem_req_o low, valid low, first address RESET_PC; with IPQ_BYPASS_EN, empty queue + ack + ready gives valid same cycle.
